// File: rtl/serial_bit_streamer_pkg.sv
// Shared constants for the serial streamer and the downstream "101" sequence detector.
// Both blocks import this so their state encodings stay in one place.
package serial_bit_streamer_pkg;

    localparam int STREAM_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } stream_state_e;

    // Detector states: longest matched prefix of "101"; DET_S101 marks a hit.
    typedef enum logic [1:0] {
        DET_S0   = 2'd0,
        DET_S1   = 2'd1,
        DET_S10  = 2'd2,
        DET_S101 = 2'd3
    } det_state_e;

endpackage

// File: rtl/serial_bit_streamer.sv
// Parallel-to-serial streamer: accepts a WIDTH-bit word and emits it one bit per
// shift_en strobe, reloading on the last bit so consecutive words stream gap-free.
module serial_bit_streamer
    import serial_bit_streamer_pkg::*;
#(
    parameter int WIDTH     = STREAM_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             load_ready_o,
    input  logic             shift_en_i,
    output logic             sequence_out_o,
    output logic             bit_valid_o,
    output logic             frame_done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_FULL = cnt_t'(WIDTH);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    stream_state_e    state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    cnt_t             cnt_q, cnt_d;

    logic consume;
    logic last_bit;
    logic xfer;
    logic head;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        head     = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
        consume  = (state_q == ST_SHIFT) && shift_en_i;
        last_bit = consume && (cnt_q == CNT_ONE);

        // Ready on the last bit lets the next word land without an idle cycle.
        load_ready_o   = (state_q == ST_IDLE) || last_bit;
        xfer           = load_valid_i && load_ready_o;
        sequence_out_o = (state_q == ST_SHIFT) ? head : 1'b0;
        bit_valid_o    = consume;
        frame_done_o   = last_bit;

        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;

        if (consume) begin
            sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
            cnt_d = cnt_q - CNT_ONE;
            if (last_bit) state_d = ST_IDLE;
        end

        // A capture wins over the shift result of the same cycle.
        if (xfer) begin
            sr_d    = load_data_i;
            cnt_d   = CNT_FULL;
            state_d = ST_SHIFT;
        end
    end

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Table/scoreboard bench: MSB-first and LSB-first instances share stimulus; each
// cycle's expected outputs are queued at drive time and checked on the falling edge.
module tb_serial_bit_streamer;
    import serial_bit_streamer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, lv, se;
    logic [7:0] ld;
    logic       rdy_m, sm, bv_m, fd_m;
    logic       rdy_l, sl, bv_l, fd_l;

    always #5 clk = ~clk;

    serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .load_valid_i(lv), .load_data_i(ld),
        .load_ready_o(rdy_m), .shift_en_i(se), .sequence_out_o(sm),
        .bit_valid_o(bv_m), .frame_done_o(fd_m));

    serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .load_valid_i(lv), .load_data_i(ld),
        .load_ready_o(rdy_l), .shift_en_i(se), .sequence_out_o(sl),
        .bit_valid_o(bv_l), .frame_done_o(fd_l));

    typedef struct {
        logic       chk;
        logic       rst_n;
        logic       lv;
        logic [7:0] ld;
        logic       se;
        logic       rdy;
        logic       sm;
        logic       sl;
        logic       bv;
        logic       fd;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   vec_no = 0;

    function automatic vec_t mk(logic r, logic l, logic [7:0] d, logic s,
                                logic rdy, logic m, logic lb, logic bv, logic fd);
        vec_t v;
        v.chk = 1'b1; v.rst_n = r; v.lv = l; v.ld = d; v.se = s;
        v.rdy = rdy; v.sm = m; v.sl = lb; v.bv = bv; v.fd = fd;
        return v;
    endfunction

    function automatic vec_t idle_vec(logic l, logic [7:0] d, logic s);
        return mk(1'b1, l, d, s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Cycle i (0-based) of a word streamed with shift_en held high.
    function automatic vec_t word_vec(logic [7:0] w, int i, logic l, logic [7:0] nd);
        logic last;
        last = (i == 7);
        return mk(1'b1, l, nd, 1'b1, last, w[7-i], w[i], 1'b1, last);
    endfunction

    task automatic check(string nm, logic act, logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %0b expected %0b", nm, vec_no, act, exp);
    endtask

    task automatic step(vec_t v);
        @(posedge clk);
        #1;
        rst_n = v.rst_n; lv = v.lv; ld = v.ld; se = v.se;
        if (v.chk) sb.push_back(v);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            vec_no++;
            check("load_ready_m", rdy_m, e.rdy);
            check("load_ready_l", rdy_l, e.rdy);
            check("seq_out_msb",  sm,    e.sm);
            check("seq_out_lsb",  sl,    e.sl);
            check("bit_valid_m",  bv_m,  e.bv);
            check("bit_valid_l",  bv_l,  e.bv);
            check("frame_done_m", fd_m,  e.fd);
            check("frame_done_l", fd_l,  e.fd);
        end
    end

    initial begin
        logic [7:0]  w;
        det_state_e  det;
        int          hits;
        bit          seen_done;
        vec_t        v;

        rst_n = 1'b0; lv = 1'b0; ld = '0; se = 1'b0;

        // Single words in both bit orders, then back-to-back FF/00 with valid held.
        w = 8'hA6;
        tbl.push_back(idle_vec(1'b1, w, 1'b1));
        for (int i = 0; i < 8; i++) tbl.push_back(word_vec(w, i, 1'b0, 8'h00));
        tbl.push_back(idle_vec(1'b0, 8'h00, 1'b1));
        w = 8'hB4;
        tbl.push_back(idle_vec(1'b1, w, 1'b1));
        for (int i = 0; i < 8; i++) tbl.push_back(word_vec(w, i, 1'b0, 8'h00));
        tbl.push_back(idle_vec(1'b0, 8'h00, 1'b0));
        w = 8'hFF;
        tbl.push_back(idle_vec(1'b1, w, 1'b1));
        for (int i = 0; i < 8; i++) tbl.push_back(word_vec(w, i, 1'b1, 8'h00));
        w = 8'h00;
        for (int i = 0; i < 8; i++) tbl.push_back(word_vec(w, i, 1'b0, 8'h00));
        tbl.push_back(idle_vec(1'b0, 8'h00, 1'b1));

        // Reset: first edge brings state out of X, second cycle is checked.
        v = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        v.chk = 1'b0;
        step(v);
        step(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(idle_vec(1'b0, 8'h00, 1'b1));

        foreach (tbl[k]) step(tbl[k]);

        // Stall for three cycles with the 4th bit at the head.
        w = 8'hB4;
        step(idle_vec(1'b1, w, 1'b1));
        for (int i = 0; i < 3; i++) step(word_vec(w, i, 1'b0, 8'h00));
        for (int i = 0; i < 3; i++)
            step(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, w[4], w[3], 1'b0, 1'b0));
        for (int i = 3; i < 8; i++) step(word_vec(w, i, 1'b0, 8'h00));
        step(idle_vec(1'b0, 8'h00, 1'b1));

        // Reset on the 4th bit of A5 aborts the word; 0F then streams normally.
        w = 8'hA5;
        step(idle_vec(1'b1, w, 1'b1));
        for (int i = 0; i < 3; i++) step(word_vec(w, i, 1'b0, 8'h00));
        step(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, w[4], w[3], 1'b1, 1'b0));
        step(idle_vec(1'b0, 8'h00, 1'b1));
        w = 8'h0F;
        step(idle_vec(1'b1, w, 1'b1));
        for (int i = 0; i < 8; i++) step(word_vec(w, i, 1'b0, 8'h00));
        step(idle_vec(1'b0, 8'h00, 1'b1));

        // Reset beats a simultaneous transfer.
        step(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(idle_vec(1'b0, 8'h00, 1'b1));
        step(idle_vec(1'b0, 8'h00, 1'b1));

        // Chain the MSB-first stream of 0A into a "101" detector.
        w = 8'h0A;
        step(idle_vec(1'b1, w, 1'b1));
        @(negedge clk);
        det = DET_S0; hits = 0; seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            @(posedge clk);
            #1;
            lv = 1'b0; ld = '0; se = 1'b1;
            @(negedge clk);
            if (bv_m) begin
                case (det)
                    DET_S0:   det = sm ? DET_S1   : DET_S0;
                    DET_S1:   det = sm ? DET_S1   : DET_S10;
                    DET_S10:  det = sm ? DET_S101 : DET_S0;
                    default:  det = sm ? DET_S1   : DET_S10;
                endcase
                if (det == DET_S101) hits++;
            end
            if (fd_m) seen_done = 1'b1;
        end
        n_chk++;
        if (seen_done) n_pass++;
        else $display("FAIL detector_frame_done: got timeout expected pulse");
        n_chk++;
        if (hits == 1) n_pass++;
        else $display("FAIL detector_hits: got %0d expected 1", hits);

        repeat (2) @(negedge clk);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_bit_streamer.md
SERIAL_BIT_STREAMER -- requirements
Module: serial_bit_streamer

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per loaded word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 emitted first, 0 = bit 0 emitted first.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clock edge.
REQ-005 load_valid  input  1  producer presents a word on load_data.
REQ-006 load_data  input  WIDTH  parallel word to serialise.
REQ-007 load_ready  output  1  block accepts load_data this cycle.
REQ-008 shift_en  input  1  downstream advance strobe; 0 stalls the stream.
REQ-009 sequence_out  output  1  serial bit, drives the sequence detector's serial input.
REQ-010 bit_valid  output  1  sequence_out carries a stream bit this cycle.
REQ-011 frame_done  output  1  one-cycle pulse when the last bit of a word is consumed.

Function
REQ-012 FSM SHALL have two states: IDLE (no word held) and SHIFT (word held, bits remaining).
REQ-013 Transfer SHALL occur when load_valid and load_ready are both 1 at a rising edge.
REQ-014 load_ready SHALL be 1 in IDLE, and in SHIFT only when the remaining-bit count is 1 and shift_en is 1; otherwise 0.
REQ-015 On transfer, load_data SHALL be captured into a WIDTH-bit shift register and remaining count set to WIDTH; state becomes SHIFT.
REQ-016 In SHIFT, sequence_out SHALL equal the current head bit of the shift register (MSB or LSB per MSB_FIRST); in IDLE sequence_out SHALL be 0.
REQ-017 bit_valid SHALL equal (state == SHIFT) AND shift_en.
REQ-018 A bit is consumed on each rising edge with state SHIFT and shift_en 1: register shifts toward the head, vacated bit fills with 0, count decrements by 1.
REQ-019 With shift_en 0 in SHIFT, shift register, count, and sequence_out SHALL hold.
REQ-020 First bit SHALL appear on sequence_out in the cycle after transfer (latency 1).
REQ-021 When the bit consumed has count 1, frame_done SHALL be 1 that same cycle; otherwise 0.
REQ-022 Last-bit consumption without a simultaneous transfer SHALL return the FSM to IDLE.
REQ-023 Last-bit consumption with a simultaneous transfer SHALL reload and remain in SHIFT, giving a gap-free stream (no idle bit between words).
REQ-024 load_valid while load_ready is 0 SHALL be ignored; the word is not captured and the producer holds it.
REQ-025 Count register width SHALL be ceil(log2(WIDTH+1)); count never wraps below 0.

Reset
REQ-026 With reset 0 at a rising edge: state IDLE, shift register 0, count 0.
REQ-027 Outputs during/after reset: sequence_out 0, bit_valid 0, frame_done 0, load_ready 1 (once reset released).
REQ-028 Reset mid-word SHALL discard remaining bits; no frame_done is produced for the aborted word.
REQ-029 Reset SHALL override any simultaneous transfer on the same edge.

Structure
REQ-030 State encoding (IDLE, SHIFT) SHALL live in a shared package with the detector's state constants; WIDTH default is a package constant.
REQ-031 Block SHALL be a single module; no sub-module; outputs are combinational functions of registered state and shift_en only.

Verification
REQ-032 MSB_FIRST=1, load 8'b1010_0110, shift_en held 1 -> sequence_out 1,0,1,0,0,1,1,0 on cycles 1..8 after transfer, bit_valid 1 on all 8, frame_done only on cycle 8, then IDLE.
REQ-033 MSB_FIRST=0, load 8'hB4 -> sequence_out 0,0,1,0,1,1,0,1; frame_done on 8th bit.
REQ-034 Back-to-back: load 8'hFF then 8'h00 with load_valid held -> 16 contiguous valid bits (eight 1s, eight 0s), load_ready high only on cycle 8, two frame_done pulses.
REQ-035 Stall: shift_en 0 for 3 cycles after bit 3 -> sequence_out holds bit 3, bit_valid 0 during stall, total stream unchanged, frame_done delayed 3 cycles.
REQ-036 Reset asserted at bit 4 of 8'hA5 -> next cycle IDLE, sequence_out 0, no frame_done; next load 8'h0F streams correctly.
REQ-037 Chained with the detector: stream 8'b0000_1010 MSB-first -> detector output asserts once after the "101" pattern completes.
